song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Score player that sits directly upstream of the beeper tone/PWM stage and drives its 8-bit note-code input.
- Walks a synchronous score ROM of packed {beats, tone} entries and holds each tone for its duration.
- Inserts a short silent gap before each next note so repeated notes articulate.
- Supports start, pause, stop, optional looping and a one-cycle end-of-song pulse.

Parameters:
BEAT_CYCLES, 12500000, clock cycles per beat (0.25 s at 50 MHz); must be >= 2
GAP_CYCLES, 500000, silent cycles at the end of each note; 0 <= GAP_CYCLES < BEAT_CYCLES
ADDR_W, 8, score ROM address width
LOOP, 0, 1 = restart at address 0 on end-of-score instead of finishing

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
start  in  1  single-cycle pulse; begins playback from address 0
pause  in  1  level; freezes playback while high
stop  in  1  single-cycle pulse; aborts playback
rom_addr  out  ADDR_W  score ROM address
rom_data  in  8  ROM entry, valid one cycle after rom_addr is presented; [7:4] beats, [3:0] tone code
note_out  out  8  note code to the beeper stage: {4'b0000, tone}; 0 = silence
playing  out  1  high from start acceptance until finish or abort
done  out  1  one-cycle pulse on natural end of score

Behaviour:
- All outputs are registered. Reset (rst=0 at a clk edge):
  - state IDLE
  - rom_addr=0, note_out=0, playing=0, done=0
  - all counters 0
  - reset mid-playback aborts immediately; no done pulse.
- Tone codes: 1-7 middle M1-M7, 9-15 low L1-L7, 0/8 rest. Codes are passed through unmodified; rests still consume their duration.
- Entry with beats=0 is the end-of-score terminator.
- States:
  - IDLE: note_out=0.
    - start=1 and stop=0 -> FETCH; rom_addr<=0; playing<=1.
  - FETCH: exactly 1 cycle, while the ROM registers its output -> LOAD.
  - LOAD: samples rom_data.
    - beats=0, LOOP=0 -> IDLE; done<=1 for one cycle; playing<=0; rom_addr<=0.
    - beats=0, LOOP=1 -> FETCH; rom_addr<=0; no done pulse.
    - beats!=0 -> PLAY; cur_tone<=tone; note_out<={4'b0,tone}; beat_left<=beats; cyc_cnt<=0.
  - PLAY: cyc_cnt counts 0..BEAT_CYCLES-1, then wraps and beat_left decrements.
    - On the last beat, when cyc_cnt==BEAT_CYCLES-GAP_CYCLES-1 -> GAP; note_out<=0.
    - With GAP_CYCLES=0 this condition is cyc_cnt==BEAT_CYCLES-1 and GAP is skipped; the advance rule below applies directly.
  - GAP: cyc_cnt continues; at BEAT_CYCLES-1 the note advances.
- Advance rule:
  - rom_addr==2^ADDR_W-1 -> treat as end-of-score, same as a terminator: done/loop handling, no address wrap to a fresh read.
  - otherwise rom_addr<=rom_addr+1 -> FETCH.
- Timing per entry:
  - LOAD to next LOAD = beats*BEAT_CYCLES+2 cycles.
  - note_out non-zero for beats*BEAT_CYCLES-GAP_CYCLES cycles (rest codes output their code).
  - Silent for GAP_CYCLES+2 cycles (GAP, FETCH, LOAD).
  - Latency from start pulse to first non-zero note_out: 3 cycles.
- Pause:
  - In PLAY/GAP, pause=1 holds cyc_cnt, beat_left and state; note_out<=0 the next cycle.
  - On release in PLAY, note_out<={4'b0,cur_tone} the next cycle and counting resumes.
  - Ignored in IDLE/FETCH/LOAD; takes effect on entry to PLAY.
- Stop:
  - In any state -> IDLE next cycle; note_out=0, playing=0, rom_addr=0, no done.
- Priority: rst > stop > pause > start. start is ignored outside IDLE. start and stop in the same cycle: remain IDLE.
- Counter widths: sized for BEAT_CYCLES-1 and 15 beats; no overflow permitted.

Test Plan:
Assume BEAT_CYCLES=10, GAP_CYCLES=2, ADDR_W=4, LOOP=0 unless stated.
- Reset: hold rst=0 with random inputs -> note_out=0, playing=0, done=0, rom_addr=0; start while rst=0 is ignored.
- ROM {0x21, 0x15, 0x00}, pulse start at cycle T -> note_out=0x01 for cycles T+3..T+20 (18 cycles) and 0 for 4 cycles. Then note_out=0x05 for 8 cycles, 0 for 2, FETCH, LOAD. done pulses once, playing falls with it, rom_addr returns to 0.
- Same ROM, pause high for 7 cycles starting at the 5th cycle of note 1 -> note_out=0 during the pause plus 1 cycle. Note 1 sound total still 18 cycles; whole song extended by exactly 7 cycles.
- stop pulse mid-note 2 -> next cycle note_out=0, playing=0, rom_addr=0, done never asserted; a later start replays from entry 0.
- LOOP=1, ROM {0x13, 0x00} -> tone 3 repeats every 10+2+2=14 cycles indefinitely; done never asserted.
- ADDR_W=2, ROM {0x11,0x12,0x13,0x14} with no terminator -> four notes play, then done pulses after entry 3 with no fifth fetch of address 0.

Source files
------------

// File: rtl/song_sequencer_if.sv
// Purpose: control, score-ROM and beeper-side signals of the song sequencer.
// Latency: none, wires only.
// Backpressure: none; pause is a level hold, start/stop are single-cycle pulses.
interface song_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              pause;
    logic              stop;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [7:0]        note_out;
    logic              playing;
    logic              done;

    // Sequencer side
    modport master (
        input  start, pause, stop, rom_data,
        output rom_addr, note_out, playing, done
    );

    // Controller / ROM / beeper side
    modport slave (
        output start, pause, stop, rom_data,
        input  rom_addr, note_out, playing, done
    );
endinterface

// File: rtl/song_sequencer.sv
// Purpose: walks a {beats,tone} score ROM and drives the beeper note code, with a silent gap per note.
// Latency: start pulse to first sounding note_out is 3 cycles; entry to entry is beats*BEAT_CYCLES+2.
// Backpressure: pause level freezes PLAY/GAP timing and mutes output; stop aborts to IDLE.
module song_sequencer #(
    parameter int BEAT_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 500000,
    parameter int ADDR_W      = 8,
    parameter bit LOOP        = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    song_sequencer_if.master sq
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam int          CW        = $clog2(BEAT_CYCLES);
    localparam logic [CW-1:0] CYC_LAST  = CW'(BEAT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_SOUND = CW'(BEAT_CYCLES - GAP_CYCLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        note_q, note_d;
    logic              playing_q, playing_d;
    logic              done_q, done_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [3:0]        beat_q, beat_d;
    logic [3:0]        tone_q, tone_d;

    logic [3:0] rom_beats;
    logic [3:0] rom_tone;
    logic       last_addr;
    logic       beat_end;
    logic       sound_end;
    logic       advance;
    logic       end_song;
    state_t     end_state;
    state_t     adv_state;

    assign rom_beats = sq.rom_data[7:4];
    assign rom_tone  = sq.rom_data[3:0];
    assign last_addr = &rom_addr_q;
    assign beat_end  = (cyc_q == CYC_LAST);
    // Sounding portion of a note ends on its last beat, GAP_CYCLES before the beat boundary.
    assign sound_end = (beat_q == 4'd1) && (cyc_q == CYC_SOUND);
    // End of score either finishes or rewinds; the top address never wraps into a fresh read.
    assign end_state = LOOP ? S_FETCH : S_IDLE;
    assign adv_state = last_addr ? end_state : S_FETCH;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state decode; stop overrides everything, pause only matters in PLAY/GAP
    always_comb begin
        state_d = state_q;
        if (sq.stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (sq.start) state_d = S_FETCH;
                S_FETCH: state_d = S_LOAD;
                S_LOAD:  state_d = (rom_beats == 4'd0) ? end_state : S_PLAY;
                S_PLAY:  if (!sq.pause && sound_end)
                             state_d = (GAP_CYCLES == 0) ? adv_state : S_GAP;
                S_GAP:   if (!sq.pause && beat_end) state_d = adv_state;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output and datapath next values, all of which land in registers
    always_comb begin
        rom_addr_d = rom_addr_q;
        note_d     = note_q;
        playing_d  = playing_q;
        done_d     = 1'b0;
        cyc_d      = cyc_q;
        beat_d     = beat_q;
        tone_d     = tone_q;
        advance    = 1'b0;
        end_song   = 1'b0;
        if (sq.stop) begin
            rom_addr_d = '0;
            note_d     = 8'd0;
            playing_d  = 1'b0;
            cyc_d      = '0;
            beat_d     = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    note_d = 8'd0;
                    if (sq.start) begin
                        rom_addr_d = '0;
                        playing_d  = 1'b1;
                    end
                end
                S_LOAD: begin
                    if (rom_beats == 4'd0) begin
                        end_song = 1'b1;
                    end else begin
                        tone_d = rom_tone;
                        note_d = {4'b0000, rom_tone};
                        beat_d = rom_beats;
                        cyc_d  = '0;
                    end
                end
                S_PLAY: begin
                    if (sq.pause) begin
                        note_d = 8'd0;
                    end else if (sound_end) begin
                        if (GAP_CYCLES == 0) begin
                            advance = 1'b1;
                        end else begin
                            note_d = 8'd0;
                            cyc_d  = cyc_q + CW'(1);
                        end
                    end else if (beat_end) begin
                        note_d = {4'b0000, tone_q};
                        cyc_d  = '0;
                        beat_d = beat_q - 4'd1;
                    end else begin
                        note_d = {4'b0000, tone_q};
                        cyc_d  = cyc_q + CW'(1);
                    end
                end
                S_GAP: begin
                    if (!sq.pause) begin
                        if (beat_end) advance = 1'b1;
                        else          cyc_d   = cyc_q + CW'(1);
                    end
                end
                default: ;
            endcase

            if (advance) begin
                note_d = 8'd0;
                cyc_d  = '0;
                if (last_addr) end_song   = 1'b1;
                else           rom_addr_d = rom_addr_q + ADDR_W'(1);
            end

            if (end_song) begin
                rom_addr_d = '0;
                note_d     = 8'd0;
                if (!LOOP) begin
                    done_d    = 1'b1;
                    playing_d = 1'b0;
                end
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rom_addr_q <= '0;
            note_q     <= 8'd0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
            cyc_q      <= '0;
            beat_q     <= 4'd0;
            tone_q     <= 4'd0;
        end else begin
            rom_addr_q <= rom_addr_d;
            note_q     <= note_d;
            playing_q  <= playing_d;
            done_q     <= done_d;
            cyc_q      <= cyc_d;
            beat_q     <= beat_d;
            tone_q     <= tone_d;
        end
    end

    assign sq.rom_addr = rom_addr_q;
    assign sq.note_out = note_q;
    assign sq.playing  = playing_q;
    assign sq.done     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Purpose: directed checks of song_sequencer timing, pause, stop, loop and address-end handling.
// Latency: samples on the falling edge, one sample per clock after each stimulus edge.
// Backpressure: pause/stop driven as directed vectors from the capture task.
module tb_song_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    song_sequencer_if #(.ADDR_W(4)) if0 ();
    song_sequencer_if #(.ADDR_W(4)) if1 ();
    song_sequencer_if #(.ADDR_W(2)) if2 ();

    song_sequencer #(.BEAT_CYCLES(10), .GAP_CYCLES(2), .ADDR_W(4), .LOOP(1'b0))
        u0 (.clk(clk), .rst(rst), .sq(if0));
    song_sequencer #(.BEAT_CYCLES(10), .GAP_CYCLES(2), .ADDR_W(4), .LOOP(1'b1))
        u1 (.clk(clk), .rst(rst), .sq(if1));
    song_sequencer #(.BEAT_CYCLES(10), .GAP_CYCLES(2), .ADDR_W(2), .LOOP(1'b0))
        u2 (.clk(clk), .rst(rst), .sq(if2));

    logic [7:0] rom0 [16];
    logic [7:0] rom1 [16];
    logic [7:0] rom2 [4];

    // Synchronous score ROMs: data valid one cycle after the address
    always @(posedge clk) begin
        if0.rom_data <= rom0[if0.rom_addr];
        if1.rom_data <= rom1[if1.rom_addr];
        if2.rom_data <= rom2[if2.rom_addr];
    end

    int ntot = 0;
    int nbad = 0;

    logic [7:0] tr_note [0:127];
    logic       tr_play [0:127];
    logic       tr_done [0:127];
    logic [7:0] tr_addr [0:127];

    task automatic drive(input int sel, input logic st, input logic pa, input logic sp);
        if0.start = (sel == 0) ? st : 1'b0;
        if0.pause = (sel == 0) ? pa : 1'b0;
        if0.stop  = (sel == 0) ? sp : 1'b0;
        if1.start = (sel == 1) ? st : 1'b0;
        if1.pause = (sel == 1) ? pa : 1'b0;
        if1.stop  = (sel == 1) ? sp : 1'b0;
        if2.start = (sel == 2) ? st : 1'b0;
        if2.pause = (sel == 2) ? pa : 1'b0;
        if2.stop  = (sel == 2) ? sp : 1'b0;
    endtask

    // k=0 drives the opening start/stop; sample k is taken k clock edges later
    task automatic capture(input int sel, input int n, input logic st0, input logic sp0,
                           input int st_k, input int stop_k, input int ps, input int pl);
        @(negedge clk);
        drive(sel, st0, 1'b0, sp0);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            case (sel)
                0: begin
                    tr_note[k] = if0.note_out; tr_play[k] = if0.playing;
                    tr_done[k] = if0.done;     tr_addr[k] = {4'b0, if0.rom_addr};
                end
                1: begin
                    tr_note[k] = if1.note_out; tr_play[k] = if1.playing;
                    tr_done[k] = if1.done;     tr_addr[k] = {4'b0, if1.rom_addr};
                end
                default: begin
                    tr_note[k] = if2.note_out; tr_play[k] = if2.playing;
                    tr_done[k] = if2.done;     tr_addr[k] = {6'b0, if2.rom_addr};
                end
            endcase
            drive(sel, (k == st_k), (k >= ps) && (k < ps + pl), (k == stop_k));
        end
    endtask

    task automatic test_reset();
        logic [39:0] obs;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            obs = {if0.note_out, if0.playing, if0.done, if0.rom_addr,
                   if1.note_out, if1.playing, if1.done, if1.rom_addr,
                   if2.note_out, if2.playing, if2.done, if2.rom_addr};
            ntot++;
            if (obs !== 40'd0) begin
                nbad++;
                $display("FAIL reset_hold cycle %0d: outputs=%h expected 0", i, obs);
            end
            drive(0, 1'($urandom), 1'($urandom), 1'($urandom));
            if1.start = 1'($urandom); if2.start = 1'($urandom);
            if (i == 5) drive(0, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        obs = {if0.note_out, if0.playing, if0.done, if0.rom_addr,
               if1.note_out, if1.playing, if1.done, if1.rom_addr,
               if2.note_out, if2.playing, if2.done, if2.rom_addr};
        ntot++;
        if (obs !== 40'd0) begin
            nbad++;
            $display("FAIL reset_start_ignored: outputs=%h expected 0", obs);
        end
    endtask

    task automatic test_play();
        int         lo [5] = '{1, 3, 21, 25, 33};
        int         hi [5] = '{2, 20, 24, 32, 45};
        logic [7:0] v  [5] = '{8'h00, 8'h01, 8'h00, 8'h05, 8'h00};
        int bad;
        capture(0, 45, 1'b1, 1'b0, -1, -1, -1, 0);
        for (int s = 0; s < 5; s++) begin
            bad = -1;
            for (int k = lo[s]; k <= hi[s]; k++) if (bad < 0 && tr_note[k] !== v[s]) bad = k;
            ntot++;
            if (bad >= 0) begin
                nbad++;
                $display("FAIL play_note seg%0d k=%0d: got %h expected %h", s, bad, tr_note[bad], v[s]);
            end
        end
        bad = -1;
        for (int k = 1; k <= 45; k++) if (bad < 0 && tr_done[k] !== (k == 37)) bad = k;
        ntot++;
        if (bad >= 0) begin
            nbad++;
            $display("FAIL play_done k=%0d: got %b expected %b", bad, tr_done[bad], (bad == 37));
        end
        bad = -1;
        for (int k = 1; k <= 45; k++) if (bad < 0 && tr_play[k] !== (k <= 36)) bad = k;
        ntot++;
        if (bad >= 0) begin
            nbad++;
            $display("FAIL play_playing k=%0d: got %b expected %b", bad, tr_play[bad], (bad <= 36));
        end
        ntot++;
        if ({tr_addr[2], tr_addr[23], tr_addr[35], tr_addr[37]} !== {8'd0, 8'd1, 8'd2, 8'd0}) begin
            nbad++;
            $display("FAIL play_addr: got %h %h %h %h expected 00 01 02 00",
                     tr_addr[2], tr_addr[23], tr_addr[35], tr_addr[37]);
        end
    endtask

    task automatic test_pause();
        int         lo [7] = '{1, 3, 8, 15, 28, 32, 40};
        int         hi [7] = '{2, 7, 14, 27, 31, 39, 50};
        logic [7:0] v  [7] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h05, 8'h00};
        int bad;
        int snd;
        capture(0, 50, 1'b1, 1'b0, -1, -1, 7, 7);
        for (int s = 0; s < 7; s++) begin
            bad = -1;
            for (int k = lo[s]; k <= hi[s]; k++) if (bad < 0 && tr_note[k] !== v[s]) bad = k;
            ntot++;
            if (bad >= 0) begin
                nbad++;
                $display("FAIL pause_note seg%0d k=%0d: got %h expected %h", s, bad, tr_note[bad], v[s]);
            end
        end
        snd = 0;
        for (int k = 1; k <= 50; k++) if (tr_note[k] === 8'h01) snd++;
        ntot++;
        if (snd != 18) begin
            nbad++;
            $display("FAIL pause_sound_len: got %0d cycles expected 18", snd);
        end
        bad = -1;
        for (int k = 1; k <= 50; k++) if (bad < 0 && tr_done[k] !== (k == 44)) bad = k;
        ntot++;
        if (bad >= 0) begin
            nbad++;
            $display("FAIL pause_done k=%0d: got %b expected %b", bad, tr_done[bad], (bad == 44));
        end
    endtask

    task automatic test_stop();
        int         lo [5] = '{1, 3, 21, 25, 29};
        int         hi [5] = '{2, 20, 24, 28, 45};
        logic [7:0] v  [5] = '{8'h00, 8'h01, 8'h00, 8'h05, 8'h00};
        int bad;
        capture(0, 45, 1'b1, 1'b0, -1, 28, -1, 0);
        for (int s = 0; s < 5; s++) begin
            bad = -1;
            for (int k = lo[s]; k <= hi[s]; k++) if (bad < 0 && tr_note[k] !== v[s]) bad = k;
            ntot++;
            if (bad >= 0) begin
                nbad++;
                $display("FAIL stop_note seg%0d k=%0d: got %h expected %h", s, bad, tr_note[bad], v[s]);
            end
        end
        ntot++;
        if ({tr_play[28], tr_play[29], tr_addr[29]} !== {1'b1, 1'b0, 8'd0}) begin
            nbad++;
            $display("FAIL stop_abort: playing %b->%b addr=%h expected 1->0 addr=00",
                     tr_play[28], tr_play[29], tr_addr[29]);
        end
        bad = -1;
        for (int k = 1; k <= 45; k++) if (bad < 0 && tr_done[k] !== 1'b0) bad = k;
        ntot++;
        if (bad >= 0) begin
            nbad++;
            $display("FAIL stop_no_done k=%0d: got %b expected 0", bad, tr_done[bad]);
        end
        // Replay from entry 0, with a stray start mid-note that must be ignored
        capture(0, 24, 1'b1, 1'b0, 10, -1, -1, 0);
        bad = -1;
        for (int k = 1; k <= 24; k++)
            if (bad < 0 && tr_note[k] !== ((k >= 3 && k <= 20) ? 8'h01 : 8'h00)) bad = k;
        ntot++;
        if (bad >= 0) begin
            nbad++;
            $display("FAIL replay_note k=%0d: got %h", bad, tr_note[bad]);
        end
        ntot++;
        if (tr_addr[23] !== 8'd1) begin
            nbad++;
            $display("FAIL replay_addr: got %h expected 01", tr_addr[23]);
        end
        // Start and stop together: the in-flight song aborts and nothing restarts
        capture(0, 4, 1'b1, 1'b1, -1, -1, -1, 0);
        ntot++;
        if ({tr_play[1], tr_play[4], tr_note[1], tr_note[4]} !== 18'd0) begin
            nbad++;
            $display("FAIL start_stop_same: playing %b %b note %h %h expected all 0",
                     tr_play[1], tr_play[4], tr_note[1], tr_note[4]);
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] obs;
        capture(0, 8, 1'b1, 1'b0, -1, -1, -1, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        obs = {if0.note_out, if0.playing, if0.done, if0.rom_addr};
        @(negedge clk);
        @(negedge clk);
        ntot++;
        if ({obs, if0.note_out, if0.playing, if0.done} !== 24'd0) begin
            nbad++;
            $display("FAIL reset_mid: after_rst=%h later note=%h playing=%b done=%b expected 0",
                     obs, if0.note_out, if0.playing, if0.done);
        end
    endtask

    task automatic test_loop();
        int bad;
        logic [7:0] e;
        capture(1, 70, 1'b1, 1'b0, -1, -1, -1, 0);
        bad = -1;
        for (int k = 1; k <= 70; k++) begin
            e = (k >= 3 && ((k - 3) % 14) < 8) ? 8'h03 : 8'h00;
            if (bad < 0 && tr_note[k] !== e) bad = k;
        end
        ntot++;
        if (bad >= 0) begin
            nbad++;
            $display("FAIL loop_note k=%0d: got %h", bad, tr_note[bad]);
        end
        bad = -1;
        for (int k = 1; k <= 70; k++) if (bad < 0 && (tr_done[k] !== 1'b0 || tr_play[k] !== 1'b1)) bad = k;
        ntot++;
        if (bad >= 0) begin
            nbad++;
            $display("FAIL loop_flags k=%0d: done=%b playing=%b expected 0 1", bad, tr_done[bad], tr_play[bad]);
        end
        capture(1, 2, 1'b0, 1'b1, -1, -1, -1, 0);
        ntot++;
        if (tr_play[1] !== 1'b0) begin
            nbad++;
            $display("FAIL loop_stop: playing=%b expected 0", tr_play[1]);
        end
    endtask

    task automatic test_addr_end();
        int bad;
        logic [7:0] e;
        capture(2, 60, 1'b1, 1'b0, -1, -1, -1, 0);
        bad = -1;
        for (int k = 1; k <= 60; k++) begin
            e = 8'h00;
            for (int i = 0; i < 4; i++)
                if (k >= 3 + 12 * i && k <= 10 + 12 * i) e = 8'(i + 1);
            if (bad < 0 && tr_note[k] !== e) bad = k;
        end
        ntot++;
        if (bad >= 0) begin
            nbad++;
            $display("FAIL addr_end_note k=%0d: got %h", bad, tr_note[bad]);
        end
        bad = -1;
        for (int k = 1; k <= 60; k++)
            if (bad < 0 && (tr_done[k] !== (k == 49) || tr_play[k] !== (k <= 48))) bad = k;
        ntot++;
        if (bad >= 0) begin
            nbad++;
            $display("FAIL addr_end_flags k=%0d: done=%b playing=%b", bad, tr_done[bad], tr_play[bad]);
        end
        ntot++;
        if ({tr_addr[13], tr_addr[25], tr_addr[37], tr_addr[49], tr_addr[60]} !==
            {8'd1, 8'd2, 8'd3, 8'd0, 8'd0}) begin
            nbad++;
            $display("FAIL addr_end_addr: got %h %h %h %h %h expected 01 02 03 00 00",
                     tr_addr[13], tr_addr[25], tr_addr[37], tr_addr[49], tr_addr[60]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            rom0[i] = 8'h00;
            rom1[i] = 8'h00;
        end
        rom0[0] = 8'h21; rom0[1] = 8'h15; rom0[2] = 8'h00;
        rom1[0] = 8'h13; rom1[1] = 8'h00;
        rom2[0] = 8'h11; rom2[1] = 8'h12; rom2[2] = 8'h13; rom2[3] = 8'h14;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);

        test_reset();
        test_play();
        test_pause();
        test_stop();
        test_reset_mid();
        test_loop();
        test_addr_end();

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
